// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate data cache.
// Sits between the EX/MEM pipeline register and the backing data memory.
// A miss holds the pipeline via stall while a small FSM writes back the
// victim line (if dirty), refills it word by word, then spends one cycle in
// RESPOND so the held request completes as an ordinary hit.
module dcache_nway #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SET_BITS   = 4,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_re,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_be,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned SETS      = 1 << SET_BITS;
    localparam int unsigned WORD_BITS = $clog2(LINE_WORDS);
    localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_BITS  = ADDR_WIDTH - 2 - WORD_BITS - SET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        RESPOND
    } state_t;

    state_t state, next_state;

    // Line storage: data and tags need no reset, state bits do.
    logic [DATA_WIDTH-1:0] data_arr [WAYS][SETS][LINE_WORDS];
    logic [TAG_BITS-1:0]   tag_arr  [WAYS][SETS];
    logic [SETS-1:0]       valid_q  [WAYS];
    logic [SETS-1:0]       dirty_q  [WAYS];
    logic [WAY_BITS-1:0]   rr_ptr   [SETS];

    // Miss context latched when leaving IDLE.
    logic [WAY_BITS-1:0]  vic_way;
    logic [SET_BITS-1:0]  vic_set;
    logic [TAG_BITS-1:0]  vic_tag;
    logic [TAG_BITS-1:0]  fill_tag;
    logic [WORD_BITS-1:0] cnt;

    // Request decode.
    logic                 req;
    logic [TAG_BITS-1:0]  req_tag;
    logic [SET_BITS-1:0]  req_set;
    logic [WORD_BITS-1:0] req_word;
    logic                 unused_addr_bits;

    assign req              = cpu_re | cpu_we;
    assign req_tag          = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_set          = cpu_addr[2+WORD_BITS +: SET_BITS];
    assign req_word         = cpu_addr[2 +: WORD_BITS];
    assign unused_addr_bits = ^cpu_addr[1:0];

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic                found_inv;
    logic [WAY_BITS-1:0] vic_sel;
    logic                last_word;
    logic [WAY_BITS-1:0] ptr_next;

    assign last_word = (cnt == WORD_BITS'(LINE_WORDS - 1));
    assign ptr_next  = (rr_ptr[req_set] == WAY_BITS'(WAYS - 1)) ? '0 : rr_ptr[req_set] + 1'b1;

    // Tag compare across all ways, and victim choice: lowest invalid way, else round-robin.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        vic_sel   = rr_ptr[req_set];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_set] && (tag_arr[w][req_set] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid_q[w][req_set] && !found_inv) begin
                found_inv = 1'b1;
                vic_sel   = WAY_BITS'(w);
            end
        end
    end

    // Next-state and output decode; stall is masked while reset is held.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_rdata  = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (!cpu_we) begin
                            cpu_rdata = data_arr[hit_way][req_set][req_word];
                        end
                    end else begin
                        stall = 1'b1;
                        if (valid_q[vic_sel][req_set] && dirty_q[vic_sel][req_set]) begin
                            next_state = WRITEBACK;
                        end else begin
                            next_state = REFILL;
                        end
                    end
                end
            end
            WRITEBACK: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vic_tag, vic_set, cnt, 2'b00};
                mem_wdata = data_arr[vic_way][vic_set][cnt];
                if (mem_ack && last_word) begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {fill_tag, vic_set, cnt, 2'b00};
                if (mem_ack && last_word) begin
                    next_state = RESPOND;
                end
            end
            RESPOND: begin
                stall      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        stall = stall & rst_n;
    end

    // Control state: FSM, miss context, word counter, valid/dirty and round-robin pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            vic_way  <= '0;
            vic_set  <= '0;
            vic_tag  <= '0;
            fill_tag <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        vic_way         <= vic_sel;
                        vic_set         <= req_set;
                        vic_tag         <= tag_arr[vic_sel][req_set];
                        fill_tag        <= req_tag;
                        cnt             <= '0;
                        rr_ptr[req_set] <= ptr_next;
                    end else if (cpu_we && hit) begin
                        dirty_q[hit_way][req_set] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        cnt <= last_word ? '0 : cnt + 1'b1;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt <= last_word ? '0 : cnt + 1'b1;
                        if (last_word) begin
                            valid_q[vic_way][vic_set] <= 1'b1;
                            dirty_q[vic_way][vic_set] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line data and tag writes: byte-masked store hits in IDLE, refill words on each ack.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && cpu_we && hit) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (cpu_be[b]) begin
                    data_arr[hit_way][req_set][req_word][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
                end
            end
        end
        if ((state == REFILL) && mem_ack) begin
            data_arr[vic_way][vic_set][cnt] <= mem_rdata;
            if (last_word) begin
                tag_arr[vic_way][vic_set] <= fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (WAYS=2, SET_BITS=4, LINE_WORDS=4) against a
// word-addressed memory model with a configurable number of wait cycles.
// Model contents: word at byte address a holds 32'hC0DE_0000 | a, except 0x104.
module tb_dcache_nway;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_model [0:1023];
    int          wait_states = 0;
    int          wait_cnt = 0;
    logic [31:0] hold_addr = '0;

    logic [31:0] log_addr [0:15];
    logic [31:0] log_data [0:15];
    logic        log_we   [0:15];
    int          log_n = 0;

    dcache_nway #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .WAYS(2),
        .SET_BITS(4),
        .LINE_WORDS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_re(cpu_re),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata),
        .stall(stall),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: ack after wait_states idle cycles of a pending request.
    assign mem_ack   = mem_req && (wait_cnt == wait_states);
    assign mem_rdata = mem_model[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_req && mem_ack) wait_cnt <= 0;
        else if (mem_req)       wait_cnt <= wait_cnt + 1;
        else                    wait_cnt <= 0;
    end

    // Log each word that completes at the coming edge; verify held requests stay put.
    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            if (log_n < 16) begin
                log_addr[log_n] = mem_addr;
                log_data[log_n] = mem_wdata;
                log_we[log_n]   = mem_we;
            end
            log_n++;
            if (mem_we) mem_model[mem_addr[11:2]] = mem_wdata;
        end else if (mem_req) begin
            if (wait_cnt == 0) hold_addr = mem_addr;
            else check("hold_addr", mem_addr, hold_addr);
        end
    end

    // One CPU access held until stall drops; n = stall cycles after the request edge.
    task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be,
                             output int first_stall, output int n, output logic [31:0] rd);
        log_n     = 0;
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_be    = be;
        #1;
        first_stall = int'(stall);
        n = 0;
        while (stall && n < 100) begin
            @(posedge clk); #1;
            if (stall) n++;
        end
        rd = cpu_rdata;
        @(posedge clk); #1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic check_xfers(input string tag, input int first, input logic we, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_addr"}, log_addr[first+i], base + 32'(4*i));
            check({tag, "_we"}, 32'(log_we[first+i]), 32'(we));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          fs;
        int          n;
        logic [31:0] rd;

        for (int i = 0; i < 1024; i++) mem_model[i] = 32'hC0DE_0000 | 32'(i*4);
        mem_model[32'h104 >> 2] = 32'h1122_3344;

        // Reset state
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        do_reset();

        // Read miss, then hits in the same line
        do_access(1'b1, 1'b0, 32'h100, '0, '0, fs, n, rd);
        check("t1_first_stall", 32'(fs), 32'd1);
        check("t1_stall_cycles", 32'(n), 32'd5);
        check("t1_xfers", 32'(log_n), 32'd4);
        check_xfers("t1_refill", 0, 1'b0, 32'h100);
        check("t1_rdata", rd, 32'hC0DE_0100);
        do_access(1'b1, 1'b0, 32'h10C, '0, '0, fs, n, rd);
        check("t1_hit_stall", 32'(fs), 32'd0);
        check("t1_hit_xfers", 32'(log_n), 32'd0);
        check("t1_hit_rdata", rd, 32'hC0DE_010C);

        // Byte-masked store hit; eviction of that line must write it back
        do_access(1'b0, 1'b1, 32'h104, 32'hAABB_CCDD, 4'b0011, fs, n, rd);
        check("t2_store_stall", 32'(fs), 32'd0);
        check("t2_store_xfers", 32'(log_n), 32'd0);
        do_access(1'b1, 1'b0, 32'h104, '0, '0, fs, n, rd);
        check("t2_merged", rd, 32'h1122_CCDD);
        do_access(1'b1, 1'b0, 32'h000, '0, '0, fs, n, rd);
        check("t2_fill_way1", 32'(n), 32'd5);
        do_access(1'b1, 1'b0, 32'h400, '0, '0, fs, n, rd);
        check("t2_dirty_cycles", 32'(n), 32'd9);
        check("t2_wb_addr", log_addr[1], 32'h104);
        check("t2_wb_data", log_data[1], 32'h1122_CCDD);
        check("t2_wb_we", 32'(log_we[1]), 32'd1);

        // Dirty eviction in set 0
        do_reset();
        do_access(1'b0, 1'b1, 32'h000, 32'h1234_5678, 4'b1111, fs, n, rd);
        check("t3_store_miss", 32'(n), 32'd5);
        do_access(1'b1, 1'b0, 32'h400, '0, '0, fs, n, rd);
        check("t3_fill_400", 32'(n), 32'd5);
        do_access(1'b1, 1'b0, 32'h800, '0, '0, fs, n, rd);
        check("t3_stall_cycles", 32'(n), 32'd9);
        check("t3_xfers", 32'(log_n), 32'd8);
        check_xfers("t3_wb", 0, 1'b1, 32'h000);
        check_xfers("t3_refill", 4, 1'b0, 32'h800);
        check("t3_wb_data0", log_data[0], 32'h1234_5678);
        check("t3_wb_data1", log_data[1], 32'hC0DE_0004);
        check("t3_rdata", rd, 32'hC0DE_0800);

        // Round-robin replacement in set 0
        do_reset();
        do_access(1'b1, 1'b0, 32'h000, '0, '0, fs, n, rd);
        check("t4_miss_000", 32'(n), 32'd5);
        do_access(1'b1, 1'b0, 32'h400, '0, '0, fs, n, rd);
        check("t4_miss_400", 32'(n), 32'd5);
        do_access(1'b1, 1'b0, 32'h800, '0, '0, fs, n, rd);
        check("t4_miss_800_clean", 32'(n), 32'd5);
        do_access(1'b1, 1'b0, 32'h400, '0, '0, fs, n, rd);
        check("t4_400_hit", 32'(fs), 32'd0);
        check("t4_400_rdata", rd, 32'hC0DE_0400);
        do_access(1'b1, 1'b0, 32'h000, '0, '0, fs, n, rd);
        check("t4_000_evicted", 32'(fs), 32'd1);

        // Two wait cycles per word
        do_reset();
        wait_states = 2;
        do_access(1'b1, 1'b0, 32'h200, '0, '0, fs, n, rd);
        check("t5_stall_cycles", 32'(n), 32'd13);
        check("t5_xfers", 32'(log_n), 32'd4);
        check("t5_rdata", rd, 32'hC0DE_0200);
        wait_states = 0;

        // Reset in the middle of a refill
        do_reset();
        log_n    = 0;
        cpu_re   = 1'b1;
        cpu_addr = 32'h100;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("t6_acks_before_rst", 32'(log_n), 32'd2);
        check("t6_req_before_rst", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_req_in_rst", 32'(mem_req), 32'd0);
        check("t6_stall_in_rst", 32'(stall), 32'd0);
        cpu_re = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h100, '0, '0, fs, n, rd);
        check("t6_remiss", 32'(fs), 32'd1);
        check("t6_stall_cycles", 32'(n), 32'd5);
        check("t6_rdata", rd, 32'hC0DE_0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache.
- Sits in the Memory stage between the execute→memory pipeline register and the backing data memory.
- Generalises the single direct data memory path: configurable ways, sets and line size, plus a miss state machine.
- Asserts `stall` to the hazard unit while servicing a miss.

Parameters:
- DATA_WIDTH, 32, word width in bits (multiple of 8).
- ADDR_WIDTH, 32, CPU byte-address width.
- WAYS, 2, associativity (power of 2, ≥1).
- SET_BITS, 4, log2 of number of sets.
- LINE_WORDS, 4, words per line (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request.
- cpu_addr  in  ADDR_WIDTH  byte address, word-aligned.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_be  in  DATA_WIDTH/8  store byte enables.
- cpu_rdata  out  DATA_WIDTH  load data.
- stall  out  1  hold pipeline; request not yet complete.
- mem_req  out  1  backing-memory word transaction valid.
- mem_we  out  1  1 = write-back word, 0 = refill read.
- mem_addr  out  ADDR_WIDTH  word-aligned byte address.
- mem_wdata  out  DATA_WIDTH  write-back data.
- mem_rdata  in  DATA_WIDTH  refill data, valid with mem_ack.
- mem_ack  in  1  current word transaction complete.

Behaviour:
- Reset and clock:
  - One clock (`clk`).
  - Reset is asynchronous and active-low (`rst_n`).
- Reset values:
  - All valid, dirty and round-robin pointers cleared.
  - FSM = IDLE.
  - stall = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_rdata = 0.
- Address split:
  - offset = addr[1:0], ignored.
  - word index = next log2(LINE_WORDS) bits.
  - set = next SET_BITS bits.
  - tag = remaining upper bits.
- Lookup:
  - Combinational compare of the tag against all WAYS in the set.
  - hit = valid && tag match.
- Read hit:
  - cpu_rdata driven combinationally the same cycle; stall = 0.
  - cpu_rdata = 0 when no read hit.
- Write hit:
  - Byte-masked write into the line word on the clock edge; dirty set; stall = 0.
- cpu_re and cpu_we both high: treated as a write.
- Neither asserted: no state change.
- Miss:
  - stall = 1 combinationally in the same cycle.
  - Victim = lowest-numbered invalid way, else the set's round-robin pointer.
  - Pointer increments mod WAYS on each allocation into that set.
- FSM states:
  - IDLE: hit → stay. Miss with dirty victim → WRITEBACK; clean victim → REFILL. Victim way, set and tag are latched on the transition.
  - WRITEBACK: mem_req = 1, mem_we = 1, mem_addr = {victim tag, set, word counter, 2'b00}. Counter advances on mem_ack. Last ack → REFILL, counter cleared.
  - REFILL: mem_req = 1, mem_we = 0, mem_addr = {req tag, set, counter, 2'b00}. mem_rdata written into the victim way on each ack. Last ack → set valid, tag; clear dirty → RESPOND.
  - RESPOND: stall = 1 for one cycle, then → IDLE. The request, still held by the stalled pipeline, now hits and completes in IDLE as a normal hit (write merges and sets dirty).
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - mem_ack outside WRITEBACK/REFILL is ignored.
  - mem_ack may arrive in the same cycle mem_req rises (zero wait).
- Miss latency (cycles stall asserted):
  - Clean miss: LINE_WORDS·(1 + memory wait) + 1.
  - Dirty miss: 2·LINE_WORDS·(1 + wait) + 1.
- Counter wraps at LINE_WORDS−1; no partial-line transfers.
- The CPU request may change while in IDLE only. Inputs are ignored during WRITEBACK/REFILL; the pipeline must hold them.
- Reset mid-miss:
  - Transaction aborted; mem_req drops asynchronously.
  - All lines invalid; dirty data discarded.
- WAYS = 1 degenerates to direct-mapped; pointer unused.

Test Plan:
- Read miss then hit: cold cache, WAYS = 2, LINE_WORDS = 4, zero-wait memory; load 0x100 → stall high 5 cycles, 4 refill reads at 0x100, 0x104, 0x108, 0x10C, mem_we = 0; next cycle cpu_rdata = mem[0x100] with stall = 0; load 0x10C → hit, no mem_req.
- Byte-masked store hit: store 0xAABBCCDD to 0x104, cpu_be = 4'b0011 over line word 0x11223344 → reload reads 0x1122CCDD; dirty = 1.
- Dirty eviction: set 0 filled via 0x000 (dirtied) and 0x400; load 0x800 → 4 writes at 0x000..0x00C with the stored data, then 4 refill reads at 0x800..0x80C; stall = 9 cycles.
- Round-robin: three successive clean misses to set 0 (0x000, 0x400, 0x800) → ways 0, 1, 0 filled; pointer wraps; 0x400 still hits.
- Wait states: mem_ack delayed 2 cycles per word → mem_addr and mem_req stable through the wait; clean miss stall = 13 cycles.
- Reset mid-refill: assert rst_n = 0 after 2 refill acks → mem_req = 0 immediately, stall = 0; after release, load 0x100 misses again.
